// File: rtl/mil_tx_frame_sequencer_pkg.sv
// Shared MIL-STD-1553 definitions used by the transmit-side frame sequencer.
//   MilWordType  : 2-bit word tag carried alongside each word pushed to the transmitter.
//   CMD_*        : bit positions of the fields inside a 1553 command word.
package milStd1553;

  typedef enum logic [1:0] {
    WCOMMAND = 2'd0,
    WSTATUS  = 2'd1,
    WDATA    = 2'd2,
    WERROR   = 2'd3
  } MilWordType;

  localparam int CMD_TR_BIT = 10;
  localparam int CMD_WC_MSB = 4;
  localparam int CMD_WC_LSB = 0;

endpackage

// File: rtl/mil_tx_frame_sequencer_cmd_decoder.sv
// mil_cmd_decoder: combinational decode of a 1553 command word.
//   cmd_word [15:0] in  : command word
//   tr              out : transmit/receive bit (1 = remote terminal transmits)
//   n_words  [5:0]  out : data words the bus controller must send, 0..32
// A word count field of 0 encodes 32 words; when the RT transmits the BC sends no data.
module mil_cmd_decoder
  import milStd1553::*;
(
  input  logic [15:0] cmd_word,
  output logic        tr,
  output logic [5:0]  n_words
);

  logic [CMD_WC_MSB-CMD_WC_LSB:0] wc;
  logic [9:0]                     unused_bits;

  assign tr          = cmd_word[CMD_TR_BIT];
  assign wc          = cmd_word[CMD_WC_MSB:CMD_WC_LSB];
  // Remaining fields (RT address, subaddress) are not needed to sequence the frame.
  assign unused_bits = {cmd_word[15:CMD_TR_BIT+1], cmd_word[CMD_TR_BIT-1:CMD_WC_MSB+1]};

  always_comb begin
    n_words = 6'd0;
    if (!tr) begin
      n_words = (wc == '0) ? 6'd32 : {1'b0, wc};
    end
  end

endmodule

// File: rtl/mil_tx_frame_sequencer.sv
// mil_tx_frame_sequencer: builds one MIL-STD-1553 BC frame (command word followed by
// N data words pulled from a first-word-fall-through FIFO) and offers it word by word
// to the transmitter push port.
// Ports:
//   clk, nRst                      : clock, asynchronous active-low reset
//   start, cmd_word[15:0]          : frame request, command sampled while idle
//   busy, frame_done, frame_error  : status / one-cycle completion and abort pulses
//   fifo_empty, fifo_data, fifo_rd : FWFT data FIFO read side
//   push_request, push_type,
//   push_data, push_done           : transmitter push handshake
//   words_left[5:0]                : data words still to push in this frame
//   dbg_state[2:0]                 : current FSM state for observation
// Build option: define MIL_TX_SEQ_TIMEOUT_EN to abort a frame when the FIFO stays
// empty for TIMEOUT_CYCLES cycles while a data word is awaited.
//
// Push handshake: push_request, push_type and push_data are held stable from the
// cycle push_request rises until the cycle push_done is sampled high; push_request
// is low the cycle after. push_done while push_request is low has no effect.
module mil_tx_frame_sequencer
  import milStd1553::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [15:0] cmd_word,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd,
  output logic        push_request,
  output MilWordType  push_type,
  output logic [15:0] push_data,
  input  logic        push_done,
  output logic [5:0]  words_left,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_FETCH = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
`ifdef MIL_TX_SEQ_TIMEOUT_EN
    , S_ABORT = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] push_data_q, push_data_d;
  logic [5:0]  words_left_q, words_left_d;
  logic [5:0]  dec_n;
  logic        dec_tr_unused;

  mil_cmd_decoder u_cmd_decoder (
    .cmd_word (cmd_word),
    .tr       (dec_tr_unused),
    .n_words  (dec_n)
  );

`ifdef MIL_TX_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expired;

  // Counts consecutive empty-FIFO cycles spent waiting for a data word.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_FETCH && fifo_empty) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Expires on the TIMEOUT_CYCLES-th consecutive empty cycle.
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;
  // The timeout length only matters when the abort path is built.
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      push_data_q  <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      push_data_q  <= push_data_d;
      words_left_q <= words_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    push_data_d  = push_data_q;
    words_left_d = words_left_q;
    busy         = 1'b0;
    frame_done   = 1'b0;
    frame_error  = 1'b0;
    fifo_rd      = 1'b0;
    push_request = 1'b0;
    push_type    = WCOMMAND;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          push_data_d  = cmd_word;
          words_left_d = dec_n;
          state_d      = S_CMD;
        end
      end
      S_CMD: begin
        busy         = 1'b1;
        push_request = 1'b1;
        if (push_done) begin
          state_d = (words_left_q == 6'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (!fifo_empty) begin
          // Single pop; the head word is captured so it stays stable while offered.
          fifo_rd     = 1'b1;
          push_data_d = fifo_data;
          state_d     = S_DATA;
        end
`ifdef MIL_TX_SEQ_TIMEOUT_EN
        else if (to_expired) begin
          words_left_d = '0;
          state_d      = S_ABORT;
        end
`endif
      end
      S_DATA: begin
        busy         = 1'b1;
        push_request = 1'b1;
        push_type    = WDATA;
        if (push_done) begin
          words_left_d = words_left_q - 6'd1;
          state_d      = (words_left_q == 6'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; it is honoured from IDLE only.
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
`ifdef MIL_TX_SEQ_TIMEOUT_EN
      S_ABORT: begin
        frame_error = 1'b1;
        state_d     = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign push_data  = push_data_q;
  assign words_left = words_left_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mil_tx_frame_sequencer.sv
// Self-checking bench for mil_tx_frame_sequencer: FWFT FIFO model, transmitter model
// with programmable acceptance delay, expected-word scoreboard and a frame vector table.
module tb_mil_tx_frame_sequencer;
  import milStd1553::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic nRst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic        start;
  logic [15:0] cmd_word;
  logic        busy, frame_done, frame_error;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd;
  logic        push_request;
  logic [1:0]  push_type;
  logic [15:0] push_data;
  logic        push_done;
  logic [5:0]  words_left;
  logic [2:0]  dbg_state;

`ifdef MIL_TX_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 20;
`else
  localparam int unsigned TB_TIMEOUT = 1000;
`endif

  mil_tx_frame_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .start        (start),
    .cmd_word     (cmd_word),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .push_request (push_request),
    .push_type    (push_type),
    .push_data    (push_data),
    .push_done    (push_done),
    .words_left   (words_left),
    .dbg_state    (dbg_state)
  );

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd2;

  // ---------------- bookkeeping ----------------
  int tests  = 0;
  int failed = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [17:0] exp_q[$];
  logic [15:0] fifo_q[$];
  bit          fifo_hold = 1'b0;
  int          tx_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FWFT FIFO model ----------------
  bit rd_seen;
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = 16'h0;
    rd_seen    = 1'b0;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd;
      if (fifo_rd) check("fifo_rd_while_empty", 32'(fifo_empty), 32'd0);
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      fifo_empty = fifo_hold || (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    end
  end

  // ---------------- transmitter model + scoreboard ----------------
  int          tx_wait;
  logic [17:0] tx_ref;
  bit          tx_stable;
  initial begin
    push_done = 1'b0;
    tx_wait   = 0;
    tx_ref    = '0;
    tx_stable = 1'b1;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        push_done = 1'b0;
        tx_wait   = 0;
      end else if (push_done) begin
        push_done = 1'b0;
        tx_wait   = 0;
      end else if (push_request) begin
        if (tx_wait == 0) begin
          tx_ref    = {push_type, push_data};
          tx_stable = 1'b1;
        end else if ({push_type, push_data} !== tx_ref) begin
          tx_stable = 1'b0;
        end
        tx_wait++;
        if (tx_wait >= tx_delay) begin
          check("push_held_stable", 32'(tx_stable), 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL push_unexpected: got %0h expected no word", {push_type, push_data});
          end else begin
            logic [17:0] exp_w;
            exp_w = exp_q.pop_front();
            check("push_word", 32'({push_type, push_data}), 32'(exp_w));
            if (push_type == WDATA)
              check("words_left_at_data", 32'(words_left), 32'(exp_q.size() + 1));
            else
              check("words_left_at_cmd", 32'(words_left), 32'(exp_q.size()));
          end
          push_done = 1'b1;
        end
      end
    end
  end

  // ---------------- pulse monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        check("busy_low_on_done", 32'(busy), 32'd0);
      end
      if (frame_error) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_start(input logic [15:0] cmd);
    @(posedge clk);
    #1;
    start    = 1'b1;
    cmd_word = cmd;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cmd_word = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic wait_evt(input bit want_err, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (want_err ? frame_error : frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic prep_frame(input logic [15:0] cmd, input logic [15:0] base,
                            input int n_fifo, input int exp_n, input int delay);
    fifo_q.delete();
    for (int k = 0; k < n_fifo; k++) fifo_q.push_back(base + 16'(k));
    exp_q.push_back({WCOMMAND, cmd});
    for (int k = 0; k < exp_n; k++) exp_q.push_back({WDATA, base + 16'(k)});
    tx_delay = delay;
    repeat (2) @(posedge clk);
  endtask

  task automatic finish_frame(input int exp_n, input int leftover, input int pops0, input int done0);
    bit ok;
    wait_evt(1'b0, 3000, ok);
    check("frame_done_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("fifo_pops", 32'(pop_cnt - pops0), 32'(exp_n));
    check("frame_done_once", 32'(done_cnt - done0), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("fifo_leftover", 32'(fifo_q.size()), 32'(leftover));
    check("busy_after_frame", 32'(busy), 32'd0);
    check("words_left_after_frame", 32'(words_left), 32'd0);
    check("state_idle_after_frame", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_frame(input logic [15:0] cmd, input logic [15:0] base,
                           input int n_fifo, input int exp_n, input int delay);
    int pops0, done0;
    prep_frame(cmd, base, n_fifo, exp_n, delay);
    pops0 = pop_cnt;
    done0 = done_cnt;
    send_start(cmd);
    check("busy_after_start", 32'(busy), 32'd1);
    check("words_left_after_start", 32'(words_left), 32'(exp_n));
    finish_frame(exp_n, n_fifo - exp_n, pops0, done0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
    check({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
    check({tag, "_push_request"}, 32'(push_request), 32'd0);
    check({tag, "_push_type"}, 32'(push_type), 32'(WCOMMAND));
    check({tag, "_push_data"}, 32'(push_data), 32'd0);
    check({tag, "_words_left"}, 32'(words_left), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- frame vector table ----------------
  typedef struct {
    logic [15:0] cmd;
    logic [15:0] base;
    int          n_fifo;
    int          exp_n;
  } frame_vec_t;

  frame_vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int pops0, done0, errs0;

    vecs[0] = '{16'h02A1, 16'hBEEF, 1,  1};   // tr=0 wc=1
    vecs[1] = '{16'h0420, 16'h0000, 0,  0};   // tr=1: command only
    vecs[2] = '{16'h0040, 16'h0001, 40, 32};  // wc=0 -> 32, 8 words remain
    vecs[3] = '{16'h041F, 16'h5500, 2,  0};   // tr=1 with FIFO content: untouched
    vecs[4] = '{16'h001F, 16'h7000, 31, 31};  // wc=31
    vecs[5] = '{16'hFBE5, 16'hC0DE, 6,  5};   // tr=0 wc=5 with other fields set
    vecs[6] = '{16'hFFFF, 16'h0000, 0,  0};   // tr=1

    nRst     = 1'b0;
    start    = 1'b0;
    cmd_word = 16'h0;
    #3;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 nRst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("idle");

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].cmd, vecs[v].base, vecs[v].n_fifo, vecs[v].exp_n,
                (v == 0) ? 3 : int'($urandom_range(1, 5)));
    end

    // FIFO starved after the command word.
    prep_frame(16'h0023, 16'hA000, 3, 3, 2);
    pops0 = pop_cnt;
    done0 = done_cnt;
    errs0 = err_cnt;
    fifo_hold = 1'b1;
    send_start(16'h0023);
`ifdef MIL_TX_SEQ_TIMEOUT_EN
    wait_evt(1'b1, 100, ok);
    check("timeout_error_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check("timeout_error_once", 32'(err_cnt - errs0), 32'd1);
    check("timeout_no_done", 32'(done_cnt - done0), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_words_left", 32'(words_left), 32'd0);
    check("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
    check("timeout_no_pops", 32'(pop_cnt - pops0), 32'd0);
    check("timeout_data_unsent", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    fifo_hold = 1'b0;
    fifo_q.delete();
`else
    repeat (50) @(negedge clk);
    check("starve_cmd_sent", 32'(exp_q.size()), 32'd3);
    check("starve_no_request", 32'(push_request), 32'd0);
    check("starve_state", 32'(dbg_state), 32'(ST_FETCH));
    check("starve_busy", 32'(busy), 32'd1);
    check("starve_words_left", 32'(words_left), 32'd3);
    check("starve_no_pops", 32'(pop_cnt - pops0), 32'd0);
    check("starve_no_error", 32'(err_cnt - errs0), 32'd0);
    fifo_hold = 1'b0;
    finish_frame(3, 0, pops0, done0);
`endif

    // Start while busy is ignored.
    prep_frame(16'h02A1, 16'hBEEF, 1, 1, 3);
    pops0 = pop_cnt;
    done0 = done_cnt;
    send_start(16'h02A1);
    send_start(16'h0005);
    check("busy_start_words_left", 32'(words_left), 32'd1);
    check("busy_start_push_data", 32'(push_data), 32'h02A1);
    finish_frame(1, 0, pops0, done0);

    // Reset in the middle of a data word.
    prep_frame(16'h0003, 16'h3000, 3, 3, 10);
    pops0 = pop_cnt;
    done0 = done_cnt;
    send_start(16'h0003);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (push_request && push_type == WDATA) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_data_before_reset", 32'(ok), 32'd1);
    @(posedge clk);
    #2 nRst = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 nRst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_one_word_lost", 32'(pop_cnt - pops0), 32'd1);
    check("reset_no_done", 32'(done_cnt - done0), 32'd0);
    check_all_zero("after_reset");
    run_frame(16'h02A1, 16'hBEEF, 1, 1, 3);

    // Transmitter stalls for a long time; offered word must not move.
    run_frame(16'h0001, 16'h1234, 1, 1, 200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
